mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory port between two requesters: port 0 (core Dataflow fetch/load/store) and port 1 (secondary master, e.g. debug/DMA).
- Sits between requesters and the memory/bus subsystem.
- Latches the winning request into slave-side registers, holds it until the memory acknowledges, and routes the acknowledge back to the winner.
- A watchdog counter aborts hung transactions with a bus-error pulse.

Parameters:
DATA_SIZE, 32, data bus width (64 for RV64I builds)
ADDR_SIZE, 32, address width
BYTE_NUM, DATA_SIZE/8, byte-enable width
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack; 0 disables watchdog

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
m0_addr / m1_addr  in  ADDR_SIZE  request address
m0_wr_data / m1_wr_data  in  DATA_SIZE  store data
m0_byte_en / m1_byte_en  in  BYTE_NUM  byte enables
m0_rd_en / m1_rd_en  in  1  read request
m0_wr_en / m1_wr_en  in  1  write request
m0_ack / m1_ack  out  1  one-cycle completion pulse
m0_bus_error / m1_bus_error  out  1  one-cycle timeout pulse, coincident with ack
rd_data  out  DATA_SIZE  = mem_rd_data, broadcast; valid for grantee in ack cycle
mem_addr  out  ADDR_SIZE  latched address
mem_wr_data  out  DATA_SIZE  latched store data
mem_byte_en  out  BYTE_NUM  latched byte enables
mem_rd_en  out  1  read strobe, held until ack
mem_wr_en  out  1  write strobe, held until ack
mem_ack  in  1  memory completion
mem_rd_data  in  DATA_SIZE  memory read data
grant  out  1  index of current/last granted port

Behaviour:
- Reset (async, immediate): state IDLE; mem_rd_en = mem_wr_en = 0; mem_addr, mem_wr_data, mem_byte_en = 0; acks and errors = 0; grant = 0; watchdog = 0; last-grant = 1 (port 0 wins first under round-robin). Reset mid-transaction drops strobes in the same cycle and discards the transaction. No ack is issued.
- States: IDLE, BUSY0, BUSY1.
- Request_k = mk_rd_en | mk_wr_en. If both enables are set, the request is a write (wr_en wins, rd ignored).
- IDLE: if no request, stay. Otherwise pick the winner per the policy (Optional Feature). At the edge, capture the winner's addr/wr_data/byte_en/op into the mem_* registers, set grant, go BUSYk.
- Latency: request visible in IDLE at cycle N gives mem_*_en high from cycle N+1.
- BUSYk: mem_* outputs are constant. Master-side inputs are ignored, so a master dropping its request does not cancel the transaction.
  - mk_ack = mem_ack (combinational, only for the granted port). The other port's ack is always 0.
  - On mem_ack: clear strobes and the watchdog, go IDLE.
- IDLE always lasts at least 1 cycle between transactions. Masters must deassert enables in the cycle after ack.
- Watchdog, when TIMEOUT_CYCLES > 0:
  - Counts BUSY cycles without mem_ack.
  - When the count reaches TIMEOUT_CYCLES and mem_ack is still 0: pulse mk_ack and mk_bus_error together for 1 cycle, clear strobes, go IDLE.
  - mem_ack arriving in the same cycle as the timeout counts as normal completion (no error).
- The losing request is not cancelled. It is re-evaluated in the next IDLE cycle.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port not granted last wins. last-grant updates on every grant.
- Undefined: fixed priority, port 0 always wins ties. last-grant logic is not synthesized. Port 1 may starve under continuous port-0 traffic.

Test Plan:
- Single read, port 0: m0_addr=0x100, rd_en=1; memory acks 3 cycles after mem_rd_en rises with 0xDEADBEEF. Expect mem_addr=0x100 and mem_rd_en=1 from cycle N+1; m0_ack pulses 1 cycle with rd_data=0xDEADBEEF; m1_ack stays 0.
- Simultaneous requests, m0 read 0x10 and m1 write 0x20/0xCAFE:
  - With MEM_ARB_ROUND_ROBIN_EN: grant order port 0 then port 1.
  - Repeated pairs with MEM_ARB_ROUND_ROBIN_EN: grants alternate.
  - Without MEM_ARB_ROUND_ROBIN_EN, repeated pairs: port 0 always served first; port 1 served only in the IDLE cycle where port 0 is idle.
- rd_en and wr_en both set on port 1: mem_wr_en=1, mem_rd_en=0.
- Request dropped mid-BUSY: m0 deasserts rd_en 1 cycle after grant. mem_rd_en stays high until mem_ack; m0_ack is still pulsed.
- Timeout with TIMEOUT_CYCLES=4 and mem_ack held 0: m1_ack and m1_bus_error pulse together 4 cycles after mem_wr_en rises; strobes drop; state IDLE. Repeat with mem_ack on the 4th cycle: ack without error.
- Reset asserted asynchronously while BUSY0: mem_rd_en drops before the next clock edge; no ack; after release, the first grant behaves as from reset.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface mem_bus_arbiter_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32
);
  localparam int unsigned BYTE_NUM = DATA_SIZE / 8;

  logic [ADDR_SIZE-1:0] m0_addr;
  logic [DATA_SIZE-1:0] m0_wr_data;
  logic [BYTE_NUM-1:0]  m0_byte_en;
  logic                 m0_rd_en;
  logic                 m0_wr_en;
  logic                 m0_ack;
  logic                 m0_bus_error;

  logic [ADDR_SIZE-1:0] m1_addr;
  logic [DATA_SIZE-1:0] m1_wr_data;
  logic [BYTE_NUM-1:0]  m1_byte_en;
  logic                 m1_rd_en;
  logic                 m1_wr_en;
  logic                 m1_ack;
  logic                 m1_bus_error;

  logic [DATA_SIZE-1:0] rd_data;
  logic                 grant;

  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wr_data;
  logic [BYTE_NUM-1:0]  mem_byte_en;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic                 mem_ack;
  logic [DATA_SIZE-1:0] mem_rd_data;

  modport slave (
    input  m0_addr, m0_wr_data, m0_byte_en, m0_rd_en, m0_wr_en,
    input  m1_addr, m1_wr_data, m1_byte_en, m1_rd_en, m1_wr_en,
    output m0_ack, m0_bus_error, m1_ack, m1_bus_error, rd_data, grant,
    output mem_addr, mem_wr_data, mem_byte_en, mem_rd_en, mem_wr_en,
    input  mem_ack, mem_rd_data
  );

  modport master (
    output m0_addr, m0_wr_data, m0_byte_en, m0_rd_en, m0_wr_en,
    output m1_addr, m1_wr_data, m1_byte_en, m1_rd_en, m1_wr_en,
    input  m0_ack, m0_bus_error, m1_ack, m1_bus_error, rd_data, grant,
    input  mem_addr, mem_wr_data, mem_byte_en, mem_rd_en, mem_wr_en,
    output mem_ack, mem_rd_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter with transaction latching and a hung-bus watchdog.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed port-0 priority.
module mem_bus_arbiter #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned BYTE_NUM = DATA_SIZE / 8;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WD_W     = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wr_data_q;
  logic [BYTE_NUM-1:0]  byte_en_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 grant_q;
  logic [WD_W-1:0]      wd_cnt;

  logic req0_c;
  logic req1_c;
  logic win_c;
  logic busy_c;
  logic timeout_c;
  logic done_c;
  logic sel_wr_c;

  assign req0_c = bus.m0_rd_en | bus.m0_wr_en;
  assign req1_c = bus.m1_rd_en | bus.m1_wr_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that was not served last wins.
  assign win_c = (req0_c && req1_c) ? ~last_grant : req1_c;
`else
  assign win_c = ~req0_c;
`endif

  // Write wins when a master raises both enables.
  assign sel_wr_c = win_c ? bus.m1_wr_en : bus.m0_wr_en;

  assign busy_c    = (state == BUSY0) || (state == BUSY1);
  assign timeout_c = WD_EN && busy_c && !bus.mem_ack
                     && (wd_cnt == WD_W'(TIMEOUT_CYCLES));
  assign done_c    = busy_c && (bus.mem_ack || timeout_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      byte_en_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      grant_q   <= 1'b0;
      wd_cnt    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_c || req1_c) begin
            state     <= win_c ? BUSY1 : BUSY0;
            grant_q   <= win_c;
            addr_q    <= win_c ? bus.m1_addr : bus.m0_addr;
            wr_data_q <= win_c ? bus.m1_wr_data : bus.m0_wr_data;
            byte_en_q <= win_c ? bus.m1_byte_en : bus.m0_byte_en;
            wr_q      <= sel_wr_c;
            rd_q      <= ~sel_wr_c;
            wd_cnt    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= win_c;
`endif
          end
        end
        BUSY0, BUSY1: begin
          // Completion or watchdog expiry both end the transaction.
          if (done_c) begin
            state  <= IDLE;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            wd_cnt <= '0;
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Acknowledge is routed straight from memory to the current grantee.
  assign bus.m0_ack       = done_c && (state == BUSY0);
  assign bus.m1_ack       = done_c && (state == BUSY1);
  assign bus.m0_bus_error = timeout_c && (state == BUSY0);
  assign bus.m1_bus_error = timeout_c && (state == BUSY1);
  assign bus.rd_data      = bus.mem_rd_data;
  assign bus.grant        = grant_q;

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.mem_byte_en = byte_en_q;
  assign bus.mem_rd_en   = rd_q;
  assign bus.mem_wr_en   = wr_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// reset/tie sequences, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned BN    = DW / 8;
  localparam int unsigned TO    = 4;
  localparam int          NRAND = 3000;
  localparam int          NVEC  = 21;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  mem_bus_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  mem_bus_arbiter #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle of inputs plus outputs expected before the following edge.
  // e = {m0_ack, m1_ack, m0_err, m1_err, mem_rd_en, mem_wr_en, grant}
  typedef struct {
    logic        r0, w0, r1, w1;
    logic [31:0] a0, a1;
    logic        mack;
    logic [31:0] mrd;
    logic [6:0]  e;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [NVEC];

  // Transaction-level reference model state.
  logic        pv, pp, pw, lastg;
  int          age;
  logic [31:0] pa, pd;
  logic [3:0]  pb;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        rr_last;
`endif

  // Random master stimulus state.
  logic        act [2];
  int          gap [2];
  logic        op_rd [2];
  logic        op_wr [2];
  logic [31:0] ad [2];
  logic [31:0] dt [2];
  logic [3:0]  be [2];

  function automatic vec_t v(input logic r0, input logic w0, input logic r1,
                             input logic w1, input logic [31:0] a0,
                             input logic [31:0] a1, input logic mack,
                             input logic [31:0] mrd, input logic [6:0] e,
                             input logic [31:0] ea);
    vec_t x;
    x.r0 = r0; x.w0 = w0; x.r1 = r1; x.w1 = w1;
    x.a0 = a0; x.a1 = a1; x.mack = mack; x.mrd = mrd;
    x.e = e; x.ea = ea;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act_v,
                     input logic [63:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic idle_in();
    bus.m0_rd_en = 1'b0; bus.m0_wr_en = 1'b0; bus.m0_addr = '0;
    bus.m0_wr_data = '0; bus.m0_byte_en = '0;
    bus.m1_rd_en = 1'b0; bus.m1_wr_en = 1'b0; bus.m1_addr = '0;
    bus.m1_wr_data = '0; bus.m1_byte_en = '0;
    bus.mem_ack = 1'b0; bus.mem_rd_data = '0;
  endtask

  task automatic model_reset();
    pv = 1'b0; pp = 1'b0; pw = 1'b0; lastg = 1'b0; age = 0;
    pa = '0; pd = '0; pb = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_last = 1'b1;
`endif
  endtask

  // Check this cycle's outputs against the model, then advance it one clock.
  task automatic model_cycle(output logic fin_o, output logic port_o);
    logic to_hit, fin, q0, q1, w;
    to_hit = pv && (TO != 0) && (age >= int'(TO));
    fin    = pv && (bus.mem_ack || to_hit);
    chk("rnd m0_ack", 64'(bus.m0_ack), 64'(fin && !pp));
    chk("rnd m1_ack", 64'(bus.m1_ack), 64'(fin && pp));
    chk("rnd m0_bus_error", 64'(bus.m0_bus_error), 64'(to_hit && !bus.mem_ack && !pp));
    chk("rnd m1_bus_error", 64'(bus.m1_bus_error), 64'(to_hit && !bus.mem_ack && pp));
    chk("rnd mem_rd_en", 64'(bus.mem_rd_en), 64'(pv && !pw));
    chk("rnd mem_wr_en", 64'(bus.mem_wr_en), 64'(pv && pw));
    chk("rnd grant", 64'(bus.grant), 64'(lastg));
    chk("rnd mem_addr", 64'(bus.mem_addr), 64'(pa));
    chk("rnd mem_wr_data", 64'(bus.mem_wr_data), 64'(pd));
    chk("rnd mem_byte_en", 64'(bus.mem_byte_en), 64'(pb));
    chk("rnd rd_data", 64'(bus.rd_data), 64'(bus.mem_rd_data));
    fin_o  = fin;
    port_o = pp;
    if (pv) begin
      if (fin) begin
        pv = 1'b0; age = 0;
      end else begin
        age++;
      end
    end else begin
      q0 = bus.m0_rd_en | bus.m0_wr_en;
      q1 = bus.m1_rd_en | bus.m1_wr_en;
      if (q0 || q1) begin
        if (q0 && q1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = !rr_last;
`else
          w = 1'b0;
`endif
        end else begin
          w = q1;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last = w;
`endif
        pv = 1'b1; pp = w; lastg = w; age = 0;
        pw = w ? bus.m1_wr_en : bus.m0_wr_en;
        pa = w ? bus.m1_addr : bus.m0_addr;
        pd = w ? bus.m1_wr_data : bus.m0_wr_data;
        pb = w ? bus.m1_byte_en : bus.m0_byte_en;
      end
    end
  endtask

  initial begin
    logic fin, port;
    int   op;
    tests = 0;
    fails = 0;

    // Directed single read, dropped/dual-enable write with timeout, ack at timeout.
    tbl[0]  = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000000, 32'h0);
    tbl[1]  = v(1,0,0,0, 32'h100, 32'h0,  0, 32'h0,        7'b0000000, 32'h0);
    tbl[2]  = v(1,0,0,0, 32'h100, 32'h0,  0, 32'h0,        7'b0000100, 32'h100);
    tbl[3]  = v(1,0,0,0, 32'h100, 32'h0,  0, 32'h0,        7'b0000100, 32'h100);
    tbl[4]  = v(1,0,0,0, 32'h100, 32'h0,  0, 32'h0,        7'b0000100, 32'h100);
    tbl[5]  = v(1,0,0,0, 32'h100, 32'h0,  1, 32'hDEADBEEF, 7'b1000100, 32'h100);
    tbl[6]  = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000000, 32'h100);
    tbl[7]  = v(0,0,1,1, 32'h0,   32'h20, 0, 32'h0,        7'b0000000, 32'h100);
    tbl[8]  = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000011, 32'h20);
    tbl[9]  = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000011, 32'h20);
    tbl[10] = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000011, 32'h20);
    tbl[11] = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000011, 32'h20);
    tbl[12] = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0101011, 32'h20);
    tbl[13] = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000001, 32'h20);
    tbl[14] = v(0,1,0,0, 32'h300, 32'h0,  0, 32'h0,        7'b0000001, 32'h20);
    tbl[15] = v(0,1,0,0, 32'h300, 32'h0,  0, 32'h0,        7'b0000010, 32'h300);
    tbl[16] = v(0,1,0,0, 32'h300, 32'h0,  0, 32'h0,        7'b0000010, 32'h300);
    tbl[17] = v(0,1,0,0, 32'h300, 32'h0,  0, 32'h0,        7'b0000010, 32'h300);
    tbl[18] = v(0,1,0,0, 32'h300, 32'h0,  0, 32'h0,        7'b0000010, 32'h300);
    tbl[19] = v(0,1,0,0, 32'h300, 32'h0,  1, 32'h12345678, 7'b1000010, 32'h300);
    tbl[20] = v(0,0,0,0, 32'h0,   32'h0,  0, 32'h0,        7'b0000000, 32'h300);

    reset = 1'b1;
    idle_in();
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset mem_rd_en", 64'(bus.mem_rd_en), 64'(0));
    chk("reset mem_wr_en", 64'(bus.mem_wr_en), 64'(0));
    chk("reset grant", 64'(bus.grant), 64'(0));
    chk("reset mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("reset mem_wr_data", 64'(bus.mem_wr_data), 64'(0));
    chk("reset mem_byte_en", 64'(bus.mem_byte_en), 64'(0));
    chk("reset acks", 64'({bus.m0_ack, bus.m1_ack, bus.m0_bus_error, bus.m1_bus_error}), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      bus.m0_rd_en = tbl[i].r0; bus.m0_wr_en = tbl[i].w0; bus.m0_addr = tbl[i].a0;
      bus.m0_wr_data = 32'hA5A5_0000 + 32'(i); bus.m0_byte_en = 4'hF;
      bus.m1_rd_en = tbl[i].r1; bus.m1_wr_en = tbl[i].w1; bus.m1_addr = tbl[i].a1;
      bus.m1_wr_data = 32'h5A5A_0000 + 32'(i); bus.m1_byte_en = 4'h3;
      bus.mem_ack = tbl[i].mack; bus.mem_rd_data = tbl[i].mrd;
      #1;
      chk($sformatf("vec%0d m0_ack", i), 64'(bus.m0_ack), 64'(tbl[i].e[6]));
      chk($sformatf("vec%0d m1_ack", i), 64'(bus.m1_ack), 64'(tbl[i].e[5]));
      chk($sformatf("vec%0d m0_bus_error", i), 64'(bus.m0_bus_error), 64'(tbl[i].e[4]));
      chk($sformatf("vec%0d m1_bus_error", i), 64'(bus.m1_bus_error), 64'(tbl[i].e[3]));
      chk($sformatf("vec%0d mem_rd_en", i), 64'(bus.mem_rd_en), 64'(tbl[i].e[2]));
      chk($sformatf("vec%0d mem_wr_en", i), 64'(bus.mem_wr_en), 64'(tbl[i].e[1]));
      chk($sformatf("vec%0d grant", i), 64'(bus.grant), 64'(tbl[i].e[0]));
      chk($sformatf("vec%0d mem_addr", i), 64'(bus.mem_addr), 64'(tbl[i].ea));
      chk($sformatf("vec%0d rd_data", i), 64'(bus.rd_data), 64'(tbl[i].mrd));
    end

    // Asynchronous reset while port 0 is being served.
    @(negedge clock);
    idle_in();
    bus.m0_rd_en = 1'b1; bus.m0_addr = 32'h44;
    @(negedge clock);
    #1;
    chk("busy0 mem_rd_en", 64'(bus.mem_rd_en), 64'(1));
    chk("busy0 mem_addr", 64'(bus.mem_addr), 64'(32'h44));
    #1;
    bus.mem_ack = 1'b1;
    reset = 1'b1;
    #1;
    chk("async reset mem_rd_en", 64'(bus.mem_rd_en), 64'(0));
    chk("async reset m0_ack", 64'(bus.m0_ack), 64'(0));
    chk("async reset mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("async reset grant", 64'(bus.grant), 64'(0));
    @(negedge clock);
    idle_in();
    reset = 1'b0;

    // Simultaneous requests after reset: port 0 first, then port 1.
    @(negedge clock);
    bus.m0_rd_en = 1'b1; bus.m0_addr = 32'h10;
    bus.m1_wr_en = 1'b1; bus.m1_addr = 32'h20; bus.m1_wr_data = 32'hCAFE;
    bus.m1_byte_en = 4'hF;
    #1;
    chk("tie idle m0_ack", 64'(bus.m0_ack), 64'(0));
    @(negedge clock);
    bus.mem_ack = 1'b1;
    #1;
    chk("tie first grant", 64'(bus.grant), 64'(0));
    chk("tie first mem_rd_en", 64'(bus.mem_rd_en), 64'(1));
    chk("tie first mem_wr_en", 64'(bus.mem_wr_en), 64'(0));
    chk("tie first mem_addr", 64'(bus.mem_addr), 64'(32'h10));
    chk("tie first m0_ack", 64'(bus.m0_ack), 64'(1));
    chk("tie first m1_ack", 64'(bus.m1_ack), 64'(0));
    @(negedge clock);
    bus.m0_rd_en = 1'b0; bus.mem_ack = 1'b0;
    #1;
    chk("tie gap strobes", 64'({bus.mem_rd_en, bus.mem_wr_en}), 64'(0));
    @(negedge clock);
    bus.mem_ack = 1'b1;
    #1;
    chk("tie second grant", 64'(bus.grant), 64'(1));
    chk("tie second mem_wr_en", 64'(bus.mem_wr_en), 64'(1));
    chk("tie second mem_addr", 64'(bus.mem_addr), 64'(32'h20));
    chk("tie second mem_wr_data", 64'(bus.mem_wr_data), 64'(32'hCAFE));
    chk("tie second mem_byte_en", 64'(bus.mem_byte_en), 64'(4'hF));
    chk("tie second m1_ack", 64'(bus.m1_ack), 64'(1));
    chk("tie second m1_bus_error", 64'(bus.m1_bus_error), 64'(0));
    @(negedge clock);
    idle_in();
    #1;
    chk("tie end mem_wr_en", 64'(bus.mem_wr_en), 64'(0));

    // Random traffic against the reference model.
    @(negedge clock);
    reset = 1'b1;
    idle_in();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; gap[k] = 0; op_rd[k] = 1'b0; op_wr[k] = 1'b0;
      ad[k] = '0; dt[k] = '0; be[k] = '0;
    end
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (!act[k]) begin
          if (gap[k] > 0) begin
            gap[k]--;
          end else if ($urandom_range(0, 2) == 0) begin
            act[k] = 1'b1;
            op = int'($urandom_range(0, 2));
            op_rd[k] = (op != 1);
            op_wr[k] = (op != 0);
            ad[k] = $urandom;
            dt[k] = $urandom;
            be[k] = 4'($urandom);
          end
        end
      end
      bus.m0_rd_en = act[0] && op_rd[0];
      bus.m0_wr_en = act[0] && op_wr[0];
      bus.m0_addr = act[0] ? ad[0] : $urandom;
      bus.m0_wr_data = act[0] ? dt[0] : $urandom;
      bus.m0_byte_en = act[0] ? be[0] : BN'($urandom);
      bus.m1_rd_en = act[1] && op_rd[1];
      bus.m1_wr_en = act[1] && op_wr[1];
      bus.m1_addr = act[1] ? ad[1] : $urandom;
      bus.m1_wr_data = act[1] ? dt[1] : $urandom;
      bus.m1_byte_en = act[1] ? be[1] : BN'($urandom);
      bus.mem_ack = ($urandom_range(0, 9) < 3);
      bus.mem_rd_data = $urandom;
      #1;
      model_cycle(fin, port);
      if (fin) begin
        act[port] = 1'b0;
        gap[port] = int'($urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
